// File: rtl/button_pkg.sv
// Shared types and elaboration-time helpers for the button front end.
package button_pkg;

  // Per-channel debounce FSM state.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_LOCK   = 2'd1,
    HELD         = 2'd2,
    RELEASE_LOCK = 2'd3
  } button_state_t;

  // Smallest n with 2**n >= value.
  function automatic int unsigned log2_ceil(input int unsigned value);
    log2_ceil = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) log2_ceil = i + 1;
    end
  endfunction

  // Counter width that covers every interval a channel has to time.
  function automatic int unsigned count_width(input int unsigned debounce,
                                               input int unsigned delay,
                                               input int unsigned period);
    int unsigned largest;
    largest = debounce;
    if (delay > largest) largest = delay;
    if (period > largest) largest = period;
    count_width = log2_ceil(largest) + 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, press/release lockout FSM and auto-repeat
// timing, all sharing a single interval counter.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = 2000000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 50000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 10000000,
  parameter int unsigned COUNT_WIDTH          = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic button_input,
  input  logic repeat_enable,
  output logic pressed,
  output logic released,
  output logic held
);

  // Last count value of a lock, of the first repeat interval measured from
  // entry into HELD (PRESS_LOCK already used DEBOUNCE_CYCLES of the delay),
  // and of every later repeat interval.
  localparam logic [COUNT_WIDTH-1:0] LOCK_LAST =
    COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] FIRST_REPEAT_LAST =
    COUNT_WIDTH'(REPEAT_DELAY_CYCLES - DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] PERIOD_LAST =
    COUNT_WIDTH'(REPEAT_PERIOD_CYCLES - 1);

  logic                   sync_meta;
  logic                   sync_level;
  button_state_t          state, state_next;
  logic [COUNT_WIDTH-1:0] count, count_next;
  logic                   repeating, repeating_next;
  logic                   pressed_next, released_next, held_next;
  logic                   repeat_due;

  // Bring the raw pin level into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
    end else begin
      sync_meta  <= button_input;
      sync_level <= sync_meta;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      repeating <= 1'b0;
      pressed   <= 1'b0;
      released  <= 1'b0;
      held      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      repeating <= repeating_next;
      pressed   <= pressed_next;
      released  <= released_next;
      held      <= held_next;
    end
  end

  assign repeat_due = repeating ? (count == PERIOD_LAST)
                                : (count == FIRST_REPEAT_LAST);

  // Next state and output pulses. The last cycle of each lock already
  // evaluates the input as the following state would, so the pulse for a
  // change hidden by the lock lands in the first cycle after the lock.
  always_comb begin
    state_next     = state;
    count_next     = count + COUNT_WIDTH'(1);
    repeating_next = repeating;
    pressed_next   = 1'b0;
    released_next  = 1'b0;
    held_next      = held;
    unique case (state)
      IDLE: begin
        count_next = '0;
        if (sync_level) begin
          pressed_next   = 1'b1;
          held_next      = 1'b1;
          repeating_next = 1'b0;
          state_next     = PRESS_LOCK;
        end
      end
      PRESS_LOCK: begin
        if (count == LOCK_LAST) begin
          count_next = '0;
          if (!sync_level) begin
            released_next = 1'b1;
            held_next     = 1'b0;
            state_next    = RELEASE_LOCK;
          end else begin
            state_next = HELD;
          end
        end
      end
      HELD: begin
        if (!sync_level) begin
          // Release wins over a repeat instant in the same cycle.
          released_next = 1'b1;
          held_next     = 1'b0;
          count_next    = '0;
          state_next    = RELEASE_LOCK;
        end else if (repeat_due) begin
          count_next     = '0;
          repeating_next = 1'b1;
          pressed_next   = repeat_enable;
        end
      end
      RELEASE_LOCK: begin
        if (count == LOCK_LAST) begin
          count_next = '0;
          if (sync_level) begin
            pressed_next   = 1'b1;
            held_next      = 1'b1;
            repeating_next = 1'b0;
            state_next     = PRESS_LOCK;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/button_bank.sv
// Bank of independent debounced button channels for the joypad inputs.
module button_bank
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES      = 2000000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 50000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 10000000,
  parameter int unsigned COUNT_WIDTH          =
    count_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_input,
  input  logic [NUM_BUTTONS-1:0] repeat_enable,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released,
  output logic [NUM_BUTTONS-1:0] held
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
    button_channel #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
      .COUNT_WIDTH          (COUNT_WIDTH)
    ) u_channel (
      .clock         (clock),
      .reset         (reset),
      .button_input  (button_input[i]),
      .repeat_enable (repeat_enable[i]),
      .pressed       (pressed[i]),
      .released      (released[i]),
      .held          (held[i])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: expected pulse events are queued when
// inputs are driven and matched against the outputs every cycle.
module tb_button_bank;

  localparam int unsigned N     = 8;
  localparam int unsigned DEB   = 4;
  localparam int unsigned DELAY = 10;
  localparam int unsigned PER   = 3;

  logic         clock;
  logic         reset;
  logic [N-1:0] button_input;
  logic [N-1:0] repeat_enable;
  logic [N-1:0] pressed;
  logic [N-1:0] released;
  logic [N-1:0] held;

  button_bank #(
    .NUM_BUTTONS          (N),
    .DEBOUNCE_CYCLES      (DEB),
    .REPEAT_DELAY_CYCLES  (DELAY),
    .REPEAT_PERIOD_CYCLES (PER)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button_input  (button_input),
    .repeat_enable (repeat_enable),
    .pressed       (pressed),
    .released      (released),
    .held          (held)
  );

  typedef struct {
    int unsigned  edge_n;
    logic [N-1:0] pressed;
    logic [N-1:0] released;
  } expect_t;

  expect_t     exp_q[$];
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges; at a falling edge cyc is the number of edges so far.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_event(input int unsigned at, input logic [N-1:0] p,
                            input logic [N-1:0] r);
    expect_t e;
    e.edge_n   = at;
    e.pressed  = p;
    e.released = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc < n) @(negedge clock);
  endtask

  // Match pulse outputs against the queued expectations each cycle.
  always @(negedge clock) begin
    expect_t e;
    while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
      check("missed_event", cyc, exp_q[0].edge_n);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
      e = exp_q.pop_front();
      check("pressed", pressed, e.pressed);
      check("released", released, e.released);
    end else if (pressed != '0 || released != '0) begin
      check("spurious_pulse", {pressed, released}, '0);
    end
  end

  task automatic repeat_run(input logic en, input int unsigned hold_len);
    int unsigned base, t0;
    repeat_enable[1] = en;
    base = cyc;
    button_input[1] = 1'b1;
    t0 = base + 3;
    push_event(t0, 8'h02, 8'h00);
    if (en) begin
      for (int unsigned t = DELAY; t < hold_len; t += PER)
        push_event(t0 + t, 8'h02, 8'h00);
    end
    push_event(t0 + hold_len, 8'h00, 8'h02);
    wait_until(base + hold_len);
    button_input[1] = 1'b0;
    wait_until(t0 + hold_len);
    check("held1_after_release", held, 8'h00);
    wait_until(t0 + hold_len + 8);
  endtask

  initial begin
    int unsigned base, t0, rel;
    reset = 1'b1;
    button_input = '0;
    repeat_enable = '0;
    repeat (3) @(negedge clock);
    check("reset_pressed", pressed, 8'h00);
    check("reset_released", released, 8'h00);
    check("reset_held", held, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single press on bit0: pulse three edges after first sample.
    base = cyc;
    button_input[0] = 1'b1;
    t0 = base + 3;
    push_event(t0, 8'h01, 8'h00);
    wait_until(t0 - 1);
    check("held0_before_press", held, 8'h00);
    wait_until(t0);
    check("held0_at_press", held, 8'h01);

    // Release after 20 held cycles, then re-press during the release lock.
    wait_until(t0 + 20);
    button_input[0] = 1'b0;
    rel = t0 + 23;
    push_event(rel, 8'h00, 8'h01);
    wait_until(rel - 1);
    check("held0_before_release", held, 8'h01);
    wait_until(rel);
    check("held0_at_release", held, 8'h00);
    wait_until(rel + 1);
    button_input[0] = 1'b1;
    push_event(rel + 4, 8'h01, 8'h00);
    wait_until(rel + 4);
    check("held0_repress", held, 8'h01);
    wait_until(rel + 10);
    button_input[0] = 1'b0;
    push_event(rel + 13, 8'h00, 8'h01);
    wait_until(rel + 20);

    // Bouncing bit2 settles high: one press, no release.
    base = cyc;
    button_input[2] = 1'b1;
    push_event(base + 3, 8'h04, 8'h00);
    @(negedge clock) button_input[2] = 1'b0;
    @(negedge clock) button_input[2] = 1'b1;
    @(negedge clock) button_input[2] = 1'b0;
    @(negedge clock) button_input[2] = 1'b1;
    wait_until(base + 12);
    check("held2_after_bounce", held, 8'h04);
    button_input[2] = 1'b0;
    push_event(base + 15, 8'h00, 8'h04);
    wait_until(base + 24);

    // Auto-repeat on bit1: enabled, disabled, and release on a repeat instant.
    repeat_run(1'b1, 24);
    repeat_run(1'b0, 24);
    repeat_run(1'b1, 25);
    repeat_enable = '0;

    // All channels together.
    base = cyc;
    button_input = 8'hFF;
    push_event(base + 3, 8'hFF, 8'h00);
    wait_until(base + 3);
    check("held_all", held, 8'hFF);
    wait_until(base + 10);
    button_input = 8'h00;
    push_event(base + 13, 8'h00, 8'hFF);
    wait_until(base + 13);
    check("held_none", held, 8'h00);
    wait_until(base + 22);

    // Reset while bit3 is held, input kept high through reset.
    base = cyc;
    button_input[3] = 1'b1;
    push_event(base + 3, 8'h08, 8'h00);
    wait_until(base + 10);
    check("held3_before_reset", held, 8'h08);
    reset = 1'b1;
    wait_until(base + 11);
    check("midreset_pressed", pressed, 8'h00);
    check("midreset_released", released, 8'h00);
    check("midreset_held", held, 8'h00);
    wait_until(base + 12);
    reset = 1'b0;
    push_event(base + 15, 8'h08, 8'h00);
    wait_until(base + 14);
    check("held3_before_fresh_press", held, 8'h00);
    wait_until(base + 15);
    check("held3_fresh_press", held, 8'h08);
    wait_until(base + 20);
    button_input[3] = 1'b0;
    push_event(base + 23, 8'h00, 8'h08);
    wait_until(base + 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
